// File: rtl/cache_read_arbiter_pkg.sv
// Shared types and constants for the cache refill read arbiter.
// Covers FSM states, owner encoding and AXI response codes.
package cache_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY) && ((resp == RESP_SLVERR) || (resp == RESP_DECERR));
  endfunction

endpackage

// File: rtl/cache_read_arbiter_if.sv
// Requester-side and AXI AR/R signals of the refill read arbiter.
// master is the arbiter's view; slave is the surrounding environment's view.
interface cache_read_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [LEN_W-1:0]  i_len;
  logic              i_ack;
  logic              i_rvalid;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [LEN_W-1:0]  d_len;
  logic              d_ack;
  logic              d_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rerr;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rlast;
  logic [1:0]        m_rresp;

  modport master (
    input  i_req, i_addr, i_len, d_req, d_addr, d_len,
    input  arready, rvalid, m_rdata, m_rlast, m_rresp,
    output i_ack, i_rvalid, d_ack, d_rvalid, rdata, rlast, rerr,
    output arvalid, araddr, arlen, rready
  );

  modport slave (
    output i_req, i_addr, i_len, d_req, d_addr, d_len,
    output arready, rvalid, m_rdata, m_rlast, m_rresp,
    input  i_ack, i_rvalid, d_ack, d_rvalid, rdata, rlast, rerr,
    input  arvalid, araddr, arlen, rready
  );

endinterface

// File: rtl/cache_read_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to
// the side that did not win last time. gnt_o[0]=I-cache, gnt_o[1]=D-cache.
module cache_read_arbiter_rr_arb2
  import cache_read_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_grant_i == OWN_D) ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/cache_read_arbiter.sv
// Shares one AXI AR/R channel between I-cache and D-cache refills.
// One burst in flight; beats are counted and steered to the owning requester.
module cache_read_arbiter
  import cache_read_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  cache_read_arbiter_if.master  bus
);

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_grant_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic [LEN_W-1:0]  beat_cnt_d;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  arlen_q;

  logic [1:0] gnt;
  owner_e     gnt_owner;
  logic       arvalid;
  logic       ar_hs;
  logic       in_r;
  logic       beat;
  logic       at_end;

  cache_read_arbiter_rr_arb2 u_arb (
    .req_i        ({bus.d_req, bus.i_req}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign gnt_owner  = gnt[1] ? OWN_D : OWN_I;
  assign arvalid    = (state_q == ST_AR);
  assign ar_hs      = arvalid && bus.arready;
  assign in_r       = (state_q == ST_R);
  assign beat       = in_r && bus.rvalid;
  assign at_end     = (beat_cnt_q == arlen_q);
  assign beat_cnt_d = beat_cnt_q + 1'b1;

  assign bus.arvalid  = arvalid;
  assign bus.araddr   = araddr_q;
  assign bus.arlen    = arlen_q;
  assign bus.rready   = in_r;
  assign bus.i_ack    = ar_hs && (owner_q == OWN_I);
  assign bus.d_ack    = ar_hs && (owner_q == OWN_D);
  assign bus.i_rvalid = beat && (owner_q == OWN_I);
  assign bus.d_rvalid = beat && (owner_q == OWN_D);
  // Data and flags are masked outside a live beat so idle outputs read as zero.
  assign bus.rdata    = beat ? bus.m_rdata : '0;
  assign bus.rlast    = beat && at_end;
  assign bus.rerr     = beat && (resp_is_err(bus.m_rresp) || (bus.m_rlast != at_end));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_D;
      last_grant_q <= OWN_D;
      beat_cnt_q   <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            owner_q      <= gnt_owner;
            last_grant_q <= gnt_owner;
            araddr_q     <= gnt[1] ? bus.d_addr : bus.i_addr;
            arlen_q      <= gnt[1] ? bus.d_len  : bus.i_len;
            state_q      <= ST_AR;
          end
        end
        ST_AR: begin
          if (bus.arready) begin
            beat_cnt_q <= '0;
            state_q    <= ST_R;
          end
        end
        ST_R: begin
          // A beat ends the burst on either m_rlast or the counted length; any
          // surplus beat from a slave that omits m_rlast sees rready=0.
          if (bus.rvalid) begin
            beat_cnt_q <= beat_cnt_d;
            if (bus.m_rlast || at_end) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_read_arbiter.sv
// Randomized bench for cache_read_arbiter with a transaction-level reference
// model compared on every falling edge, plus directed literal checks.
module tb_cache_read_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit   rand_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  cache_read_arbiter_if #(.ADDR_W(32), .DATA_W(64), .LEN_W(8)) bus ();

  cache_read_arbiter #(.ADDR_W(32), .DATA_W(64), .LEN_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending transaction with an address phase and a beat tally.
  bit          m_busy = 0, m_ar_done = 0, m_owner = 1, m_last = 1;
  logic [31:0] m_addr = '0;
  logic [7:0]  m_len  = '0;
  int          m_beats = 0;
  bit          e_arv, e_rdy, e_beat, e_rlast, e_rerr, win;
  logic [63:0] e_rdata;

  always @(negedge clock) begin
    if (reset) begin
      m_busy = 0; m_ar_done = 0; m_owner = 1; m_last = 1;
      m_addr = '0; m_len = '0; m_beats = 0;
    end
    e_arv   = m_busy && !m_ar_done;
    e_rdy   = m_busy && m_ar_done;
    e_beat  = e_rdy && bus.rvalid;
    e_rdata = e_beat ? bus.m_rdata : 64'd0;
    e_rlast = e_beat && (m_beats == int'(m_len));
    e_rerr  = e_beat && (bus.m_rresp[1] || (bus.m_rlast != (m_beats == int'(m_len))));
    check("arvalid",  64'(bus.arvalid),  64'(e_arv));
    check("araddr",   64'(bus.araddr),   64'(m_addr));
    check("arlen",    64'(bus.arlen),    64'(m_len));
    check("i_ack",    64'(bus.i_ack),    64'(e_arv && bus.arready && m_owner == 0));
    check("d_ack",    64'(bus.d_ack),    64'(e_arv && bus.arready && m_owner == 1));
    check("rready",   64'(bus.rready),   64'(e_rdy));
    check("i_rvalid", 64'(bus.i_rvalid), 64'(e_beat && m_owner == 0));
    check("d_rvalid", 64'(bus.d_rvalid), 64'(e_beat && m_owner == 1));
    check("rdata",    bus.rdata,         e_rdata);
    check("rlast",    64'(bus.rlast),    64'(e_rlast));
    check("rerr",     64'(bus.rerr),     64'(e_rerr));
    if (!reset) begin
      if (!m_busy) begin
        if (bus.i_req || bus.d_req) begin
          win = (bus.i_req && bus.d_req) ? !m_last : bus.d_req;
          m_owner = win; m_last = win;
          m_addr = win ? bus.d_addr : bus.i_addr;
          m_len  = win ? bus.d_len  : bus.i_len;
          m_busy = 1; m_ar_done = 0;
        end
      end else if (!m_ar_done) begin
        if (bus.arready) begin m_ar_done = 1; m_beats = 0; end
      end else if (e_beat) begin
        if (bus.m_rlast || m_beats == int'(m_len)) m_busy = 0;
        m_beats++;
      end
    end
  end

  // Random environment: two requesters and an AXI slave with stalls and faults.
  bit   s_hs, s_beat, s_rl, s_ia, s_da;
  logic [7:0] s_len;
  int   d_total = 0, d_idx = 0, d_mode = 0, early_at = 0;

  always begin
    @(negedge clock);
    s_hs   = bus.arvalid && bus.arready;
    s_beat = bus.rvalid && bus.rready;
    s_rl   = bus.m_rlast;
    s_ia   = bus.i_ack;
    s_da   = bus.d_ack;
    s_len  = bus.arlen;
    @(posedge clock);
    #1;
    if (rand_en) begin
      if (s_ia) bus.i_req = 0;
      if (s_da) bus.d_req = 0;
      if (!bus.i_req && $urandom_range(3) == 0) begin
        bus.i_req = 1; bus.i_addr = $urandom; bus.i_len = 8'($urandom_range(5));
      end
      if (!bus.d_req && $urandom_range(3) == 0) begin
        bus.d_req = 1; bus.d_addr = $urandom; bus.d_len = 8'($urandom_range(5));
      end
      bus.arready = ($urandom_range(2) == 0);
      if (s_hs) begin
        d_total  = int'(s_len) + 1;
        d_idx    = 0;
        d_mode   = int'($urandom_range(7));
        early_at = (s_len > 0) ? int'($urandom_range(int'(s_len) - 1)) : 0;
      end
      if (s_beat) begin
        d_idx++;
        if (s_rl) d_idx = d_total;
      end
      if (d_idx < d_total && $urandom_range(3) != 0) begin
        bus.rvalid  = 1;
        bus.m_rdata = {$urandom, $urandom};
        bus.m_rresp = ($urandom_range(5) == 0) ? 2'($urandom_range(3)) : 2'b00;
        if (d_mode == 0 && d_total > 1) bus.m_rlast = (d_idx == early_at);
        else if (d_mode == 1)           bus.m_rlast = 0;
        else                            bus.m_rlast = (d_idx == d_total - 1);
      end else begin
        bus.rvalid = 0; bus.m_rlast = 0; bus.m_rresp = 2'b00;
      end
    end
  end

  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.i_len = '0;
    bus.d_req = 0; bus.d_addr = '0; bus.d_len = '0;
    bus.arready = 0; bus.rvalid = 0; bus.m_rdata = '0; bus.m_rlast = 0; bus.m_rresp = 2'b00;

    @(negedge clock);
    check("rst_araddr",  64'(bus.araddr),  64'd0);
    check("rst_arlen",   64'(bus.arlen),   64'd0);
    check("rst_arvalid", 64'(bus.arvalid), 64'd0);
    check("rst_rlast",   64'(bus.rlast),   64'd0);

    // I-only burst, len=3, arready in cycle 2.
    @(posedge clock); #1;
    reset = 0;
    bus.i_req = 1; bus.i_addr = 32'h8000_0000; bus.i_len = 8'd3;
    @(negedge clock);
    check("c0_arvalid", 64'(bus.arvalid), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("c1_arvalid", 64'(bus.arvalid), 64'd1);
    check("c1_araddr",  64'(bus.araddr),  64'h8000_0000);
    check("c1_arlen",   64'(bus.arlen),   64'd3);
    check("c1_i_ack",   64'(bus.i_ack),   64'd0);
    @(posedge clock); #1;
    bus.arready = 1;
    @(negedge clock);
    check("c2_i_ack", 64'(bus.i_ack), 64'd1);
    check("c2_d_ack", 64'(bus.d_ack), 64'd0);
    @(posedge clock); #1;
    bus.i_req = 0; bus.arready = 0;
    for (int k = 0; k < 4; k++) begin
      bus.rvalid = 1; bus.m_rdata = 64'hA000 + 64'(k); bus.m_rlast = (k == 3);
      @(negedge clock);
      check("beat_i_rvalid", 64'(bus.i_rvalid), 64'd1);
      check("beat_d_rvalid", 64'(bus.d_rvalid), 64'd0);
      check("beat_rlast",    64'(bus.rlast),    64'(k == 3));
      check("beat_rdata",    bus.rdata,         64'hA000 + 64'(k));
      @(posedge clock); #1;
    end
    bus.rvalid = 0; bus.m_rlast = 0;
    @(negedge clock);
    check("post_rready", 64'(bus.rready), 64'd0);

    // Tie after reset goes to I; reset mid-R; then D serviced.
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    bus.i_req = 1; bus.i_addr = 32'h0000_1000; bus.i_len = 8'd1;
    bus.d_req = 1; bus.d_addr = 32'h0000_2000; bus.d_len = 8'd0;
    @(posedge clock); #1;
    @(negedge clock);
    check("tie_araddr", 64'(bus.araddr), 64'h1000);
    @(posedge clock); #1;
    bus.arready = 1;
    @(negedge clock);
    check("tie_i_ack", 64'(bus.i_ack), 64'd1);
    check("tie_d_ack", 64'(bus.d_ack), 64'd0);
    @(posedge clock); #1;
    bus.i_req = 0; bus.arready = 0;
    bus.rvalid = 1; bus.m_rdata = 64'h1111; bus.m_rlast = 0;
    @(negedge clock);
    check("tie_beat1", 64'(bus.i_rvalid), 64'd1);
    @(posedge clock); #1;
    reset = 1;
    @(negedge clock);
    check("rstR_arvalid",  64'(bus.arvalid),  64'd0);
    check("rstR_rready",   64'(bus.rready),   64'd0);
    check("rstR_i_rvalid", 64'(bus.i_rvalid), 64'd0);
    @(posedge clock); #1;
    reset = 0; bus.rvalid = 0;
    @(posedge clock); #1;
    @(negedge clock);
    check("after_rst_araddr", 64'(bus.araddr), 64'h2000);
    check("after_rst_arlen",  64'(bus.arlen),  64'd0);
    rand_en = 1;

    repeat (4000) @(posedge clock);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
